// File: rtl/op_serializer_if.sv
// Encoder-to-serializer bus: packet, valid level and the serializer's status outputs.
// The source side drives data/data_valid; the serializer drives the rest.
interface op_serializer_if #(
  parameter int WIDTH = 40
);
  logic [WIDTH-1:0] data;
  logic             data_valid;
  logic             data_ack;
  logic             sout;
  logic             busy;
  logic             frame_done;

  modport master (
    output data, data_valid,
    input  data_ack, sout, busy, frame_done
  );

  modport slave (
    input  data, data_valid,
    output data_ack, sout, busy, frame_done
  );
endinterface

// File: rtl/op_serializer.sv
// Captures an encoder packet and shifts it out MSB-first on an idle-high line,
// BIT_CYCLES clocks per bit, then holds an idle-high gap of GAP_CYCLES clocks.
//
// state | meaning
// IDLE  | line high, waiting for data_valid to capture a packet
// SHIFT | driving shreg MSB, shifting every BIT_CYCLES clocks
// GAP   | line high for GAP_CYCLES clocks before the next capture is allowed
module op_serializer #(
  parameter int WIDTH      = 40,
  parameter int BIT_CYCLES = 8,
  parameter int GAP_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst,
  op_serializer_if.slave bus
);

  localparam int MAX_CYC = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int BW      = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] BIT_TC   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_TC   = CW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [BW-1:0]    bit_q;
  logic [CW-1:0]    cyc_q;
  logic             sout_q;
  logic             busy_q;
  logic             ack_q;
  logic             done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      sout_q  <= 1'b1;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.data_valid) begin
            state_q <= SHIFT;
            shreg_q <= bus.data;
            bit_q   <= '0;
            cyc_q   <= '0;
            sout_q  <= bus.data[WIDTH-1];
            busy_q  <= 1'b1;
            ack_q   <= 1'b1;
          end
        end
        SHIFT: begin
          if (cyc_q == BIT_TC) begin
            cyc_q   <= '0;
            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            bit_q   <= bit_q + 1'b1;
            // sout is registered, so it must take the bit that the shift exposes
            if (bit_q == LAST_BIT) begin
              state_q <= GAP;
              sout_q  <= 1'b1;
            end else begin
              sout_q  <= shreg_q[WIDTH-2];
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        GAP: begin
          if (cyc_q == GAP_TC) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cyc_q   <= '0;
          bit_q   <= '0;
          sout_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sout       = sout_q;
  assign bus.busy       = busy_q;
  assign bus.data_ack   = ack_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_op_serializer.sv
// Self-checking bench for op_serializer with BIT_CYCLES=2, GAP_CYCLES=3.
// Expected line waveform is computed per cycle from the packet and frame timing rules.
module tb_op_serializer;
  localparam int W  = 40;
  localparam int BC = 2;
  localparam int GC = 3;
  localparam int FRAME = W * BC;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  op_serializer_if #(.WIDTH(W)) bus();

  op_serializer #(.WIDTH(W), .BIT_CYCLES(BC), .GAP_CYCLES(GC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int errors  = 0;

  // {sout, busy, data_ack, frame_done}
  function automatic logic [3:0] obs();
    return {bus.sout, bus.busy, bus.data_ack, bus.frame_done};
  endfunction

  function automatic logic [W-1:0] rand_pkt();
    return {8'($urandom), 32'($urandom)};
  endfunction

  // Entered at the negedge right after the capture edge; returns at the first IDLE negedge.
  task automatic check_frame(input logic [W-1:0] pkt, input string name, input bit scramble,
                             output logic [W-1:0] seen);
    logic [3:0] expv;
    seen = '0;
    for (int c = 0; c < FRAME + GC + 1; c++) begin
      if (c < FRAME)           expv = {pkt[W-1-c/BC], 1'b1, (c == 0), 1'b0};
      else if (c < FRAME + GC) expv = 4'b1100;
      else                     expv = 4'b1001;
      if (c < FRAME && (c % BC) == BC - 1) seen = {seen[W-2:0], bus.sout};
      vectors++;
      if (obs() !== expv) begin
        errors++;
        $display("FAIL %s cycle %0d: {sout,busy,ack,done} got %b want %b", name, c, obs(), expv);
      end
      if (scramble) begin
        bus.data       = '1;
        bus.data_valid = (c < FRAME + GC) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (c < FRAME + GC) @(negedge clk);
    end
  endtask

  task automatic wait_ack(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.data_ack === 1'b1) ok = 1'b1;
    end
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL %s ack_timeout: data_ack got 0 want 1 within 20 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.data = '0;
    bus.data_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (obs() !== 4'b1000) begin
        errors++;
        $display("FAIL reset_state: got %b want 1000", obs());
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [W-1:0] pkt = 40'hc671000000;
    logic [W-1:0] seen;
    bus.data = pkt;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    check_frame(pkt, "single", 1'b0, seen);
    vectors++;
    if (seen !== pkt) begin
      errors++;
      $display("FAIL single_line_word: got %h want %h", seen, pkt);
    end
  endtask

  task automatic test_keyboard();
    logic [W-1:0] pkt = 40'hc610001234;
    logic [W-1:0] seen;
    @(negedge clk);
    bus.data = pkt;
    bus.data_valid = 1'b1;
    wait_ack("keyboard");
    bus.data_valid = 1'b0;
    check_frame(pkt, "keyboard", 1'b0, seen);
    vectors++;
    if (seen[15:0] !== 16'h1234) begin
      errors++;
      $display("FAIL keyboard_low16: got %h want 1234", seen[15:0]);
    end
    repeat (10) begin
      @(negedge clk);
      vectors++;
      if (obs() !== 4'b1000) begin
        errors++;
        $display("FAIL keyboard_single_frame: got %b want 1000", obs());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] pkt;
    logic [W-1:0] seen;
    pkt = rand_pkt();
    pkt[W-1] = 1'b0;
    pkt[0] = 1'b0;
    bus.data = pkt;
    bus.data_valid = 1'b1;
    wait_ack("b2b");
    for (int f = 0; f < 3; f++) begin
      check_frame(pkt, $sformatf("b2b_frame%0d", f), 1'b0, seen);
      if (f < 2) begin
        pkt = rand_pkt();
        pkt[W-1] = 1'b0;
        pkt[0] = 1'b0;
        bus.data = pkt;
        @(negedge clk);
      end else begin
        bus.data_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_mid_change();
    logic [W-1:0] pkt = rand_pkt();
    logic [W-1:0] seen;
    bus.data = pkt;
    bus.data_valid = 1'b1;
    @(negedge clk);
    check_frame(pkt, "mid_change", 1'b1, seen);
    @(negedge clk);
    vectors++;
    if (obs() !== 4'b1000) begin
      errors++;
      $display("FAIL mid_change_after: got %b want 1000", obs());
    end
  endtask

  task automatic test_rst_mid();
    logic [W-1:0] pkt = rand_pkt();
    logic [W-1:0] seen;
    bus.data = pkt;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    for (int c = 0; c <= 30; c++) begin
      vectors++;
      if (obs() !== {pkt[W-1-c/BC], 1'b1, (c == 0), 1'b0}) begin
        errors++;
        $display("FAIL rst_mid_shift cycle %0d: got %b want %b", c, obs(),
                 {pkt[W-1-c/BC], 1'b1, (c == 0), 1'b0});
      end
      if (c < 30) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      vectors++;
      if (obs() !== 4'b1000) begin
        errors++;
        $display("FAIL rst_mid_idle: got %b want 1000", obs());
      end
      @(negedge clk);
    end
    pkt = rand_pkt();
    bus.data = pkt;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    check_frame(pkt, "rst_mid_next", 1'b0, seen);
  endtask

  task automatic test_rst_valid();
    logic [W-1:0] pkt = rand_pkt();
    logic [W-1:0] seen;
    bus.data = pkt;
    bus.data_valid = 1'b1;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (obs() !== 4'b1000) begin
        errors++;
        $display("FAIL rst_valid_no_capture: got %b want 1000", obs());
      end
    end
    rst = 1'b0;
    @(negedge clk);
    bus.data_valid = 1'b0;
    check_frame(pkt, "rst_valid_capture", 1'b0, seen);
  endtask

  task automatic test_random();
    logic [W-1:0] pkt;
    logic [W-1:0] seen;
    for (int n = 0; n < 4; n++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      pkt = rand_pkt();
      bus.data = pkt;
      bus.data_valid = 1'b1;
      @(negedge clk);
      bus.data_valid = 1'b0;
      bus.data = rand_pkt();
      check_frame(pkt, $sformatf("random%0d", n), 1'b0, seen);
      vectors++;
      if (seen !== pkt) begin
        errors++;
        $display("FAIL random%0d_word: got %h want %h", n, seen, pkt);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.data = '0;
    bus.data_valid = 1'b0;
    test_reset();
    test_single();
    test_keyboard();
    test_back_to_back();
    test_mid_change();
    test_rst_mid();
    test_rst_valid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
